difftest_runahead_commit_sched: RTL
===================================

Name: difftest_runahead_commit_sched

Overview:
Collects runahead-mode commit events from up to NUM_LANES commit lanes per cycle and buffers them in a FIFO. Drains them one per cycle onto the single-event difftest runahead-commit interface (coreid, index, valid, pc), assigning a wrapping 8-bit index per event. Sits between the backend commit stage and the runahead-commit difftest event sink. Discards its contents on runahead exit.

Parameters:
NUM_LANES, 2, commit lanes sampled per cycle (1..4)
DEPTH, 8, FIFO entries (power of 2, DEPTH >= NUM_LANES)
CORE_ID, 0, constant 8-bit value driven on io_out_coreid

Ports:
io_clock  input  1  clock, all state updates on posedge
io_reset_n  input  1  synchronous active-low reset
io_in_valid  input  NUM_LANES  per-lane commit valid; bit i = lane i
io_in_pc  input  64*NUM_LANES  per-lane commit PC; lane i at bits [64*i+63:64*i]
io_in_ready  output  1  high when free entries >= NUM_LANES
io_flush  input  1  runahead exit; drop all queued events
io_out_coreid  output  8  event core id
io_out_index  output  8  event sequence index
io_out_valid  output  1  event valid this cycle
io_out_pc  output  64  event PC
io_overflow  output  1  sticky: commits presented while not ready
io_count  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (io_reset_n=0 at posedge): FIFO empty, count=0, out_valid=0, out_pc=0, out_index=0, index counter=0, overflow=0. io_out_coreid=CORE_ID always, including during reset.
- io_in_ready = (DEPTH - count) >= NUM_LANES, combinational from registered count only. It does not depend on io_in_valid or on same-cycle dequeue.
- Enqueue when io_in_ready=1 and io_flush=0:
  - Valid lanes are compacted in ascending lane order and written at tail, tail+1, ...
  - Invalid lanes consume no entry.
  - n_enq = popcount(io_in_valid).
- Drop when io_in_ready=0, io_flush=0 and any io_in_valid bit is set:
  - All lanes are discarded; a partial accept is never done.
  - overflow is set to 1 at that edge. It is sticky and cleared only by reset.
- Dequeue: each cycle with count>0 and io_flush=0, the head entry is popped into the output registers.
  - Next cycle: out_valid=1, out_pc=head pc, out_index=index counter; the counter then increments.
  - When count=0: out_valid=0. out_pc and out_index hold their last values.
- Index counter: 8-bit, wraps 255->0. It is not cleared by flush, so it stays monotonic across runahead episodes.
- Latency: an event enqueued at edge N is popped at edge N+1 at the earliest, so io_out_valid=1 in the cycle after edge N+1. There is no bypass.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - deq. Pointers wrap modulo DEPTH. count never exceeds DEPTH, which the ready rule guarantees.
- Flush, at the edge where io_flush=1:
  - head=tail=0, count=0, out_valid=0 next cycle.
  - Same-cycle io_in_valid lanes are discarded, with no overflow set.
  - Flush has priority over both enqueue and dequeue.
- io_count = registered count.
- Reset mid-operation: same as the reset state regardless of FIFO contents. No event is emitted in the cycle after reset.
- Ordering: events leave in strict program order; lane 0 precedes lane 1 within a cycle, and earlier cycles precede later ones.

Test Plan:
- Reset then idle 5 cycles -> out_valid=0, out_index=0, out_coreid=CORE_ID, in_ready=1, count=0, overflow=0.
- Single cycle, lanes 0/1 valid with pc 0x80000000/0x80000004 -> out_valid high 2 consecutive cycles, pc 0x80000000 idx 0, then 0x80000004 idx 1. First out_valid appears 2 cycles after the input cycle.
- Lane 1 only valid (pc 0x1000), lane 0 invalid -> exactly one event, pc 0x1000, count peaks at 1.
- Both lanes valid every cycle for 10 cycles (DEPTH=8) -> in_ready drops once count reaches 7. Overflow is set on the first cycle valid is presented while not ready. Only accepted PCs emerge, in order, with indices contiguous.
- Fill 6 entries, assert io_flush with both lanes valid -> next cycle count=0, out_valid=0, overflow unchanged. The next accepted event carries the index following the last emitted one.
- Emit 300 events -> index wraps 255->0, and the PC sequence matches the input.
- Assert io_reset_n=0 with 5 entries queued -> count=0, out_valid=0, index counter=0 the next cycle.

Source files
------------

// File: rtl/difftest_runahead_commit_sched.sv
// Runahead-commit event scheduler: compacts up to NUM_LANES commit lanes into a FIFO
// and drains one event per cycle onto the difftest runahead-commit interface.
module difftest_runahead_commit_sched #(
    parameter int         NUM_LANES = 2,
    parameter int         DEPTH     = 8,
    parameter logic [7:0] CORE_ID   = 8'd0
) (
    input  logic                      io_clock,
    input  logic                      io_reset_n,
    input  logic [NUM_LANES-1:0]      io_in_valid,
    input  logic [64*NUM_LANES-1:0]   io_in_pc,
    output logic                      io_in_ready,
    input  logic                      io_flush,
    output logic [7:0]                io_out_coreid,
    output logic [7:0]                io_out_index,
    output logic                      io_out_valid,
    output logic [63:0]               io_out_pc,
    output logic                      io_overflow,
    output logic [$clog2(DEPTH):0]    io_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [63:0]          mem_r [DEPTH];
    logic [PTR_W-1:0]     head_r;
    logic [PTR_W-1:0]     tail_r;
    logic [CNT_W-1:0]     count_r;
    logic                 out_valid_r;
    logic [63:0]          out_pc_r;
    logic [7:0]           out_index_r;
    logic [7:0]           idx_r;
    logic                 overflow_r;

    logic                 ready_s;
    logic                 enq_ok_s;
    logic                 drop_s;
    logic                 deq_s;
    logic [CNT_W-1:0]     n_enq_s;
    logic [NUM_LANES-1:0] wr_en_s;
    logic [PTR_W-1:0]     wr_addr_s [NUM_LANES];

    // Ready depends on registered occupancy only, never on same-cycle dequeue.
    always_comb begin
        ready_s  = (count_r <= CNT_W'(DEPTH - NUM_LANES));
        enq_ok_s = ready_s & ~io_flush;
        drop_s   = ~ready_s & ~io_flush & (|io_in_valid);
        deq_s    = (count_r != {CNT_W{1'b0}}) & ~io_flush;
    end

    // Compact valid lanes in ascending order onto consecutive tail slots.
    always_comb begin : lane_compact
        logic [CNT_W-1:0] ofs;
        ofs = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            wr_addr_s[i] = tail_r + ofs[PTR_W-1:0];
            wr_en_s[i]   = enq_ok_s & io_in_valid[i];
            ofs          = ofs + CNT_W'(io_in_valid[i]);
        end
        if (enq_ok_s) begin
            n_enq_s = ofs;
        end else begin
            n_enq_s = {CNT_W{1'b0}};
        end
    end

    // Event storage; contents are don't-care until written, so no reset.
    always_ff @(posedge io_clock) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_en_s[i]) begin
                mem_r[wr_addr_s[i]] <= io_in_pc[64*i +: 64];
            end
        end
    end

    // Pointers, occupancy, output event registers and the sticky overflow flag.
    always_ff @(posedge io_clock) begin
        if (!io_reset_n) begin
            head_r      <= {PTR_W{1'b0}};
            tail_r      <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_pc_r    <= 64'd0;
            out_index_r <= 8'd0;
            idx_r       <= 8'd0;
            overflow_r  <= 1'b0;
        end else if (io_flush) begin
            // Index counter survives flush so indices stay monotonic across episodes.
            head_r      <= {PTR_W{1'b0}};
            tail_r      <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            tail_r  <= tail_r + n_enq_s[PTR_W-1:0];
            count_r <= count_r + n_enq_s - CNT_W'(deq_s);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (deq_s) begin
                head_r      <= head_r + PTR_W'(1);
                out_valid_r <= 1'b1;
                out_pc_r    <= mem_r[head_r];
                out_index_r <= idx_r;
                idx_r       <= idx_r + 8'd1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign io_in_ready   = ready_s;
    assign io_out_coreid = CORE_ID;
    assign io_out_index  = out_index_r;
    assign io_out_valid  = out_valid_r;
    assign io_out_pc     = out_pc_r;
    assign io_overflow   = overflow_r;
    assign io_count      = count_r;

endmodule
